uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter byte FIFO between NUM_REQ byte-stream requesters.
//  - Grants the FIFO write port to one requester for a whole packet (until req_last_i), so packets never interleave.
//  - Arbitration is round-robin.
//  - Sits between client blocks (debug, log, console) and the tx write port (tx_we/din/full) of the UART TX.
// PARAMETERS
//  NUM_REQ    4    number of requesters, 2..16
//  DATA_WIDTH 8    byte width, must equal the UART TX data width
//  MAX_BEATS  256  max data beats per grant before forced release, >=2
// PORTS
//  clk_i        in   1                   clock, all logic on posedge
//  rst_i        in   1                   asynchronous, active-high reset
//  req_valid_i  in   NUM_REQ             per-requester byte valid
//  req_data_i   in   NUM_REQ*DATA_WIDTH  packed bytes; requester k at [k*DW +: DW]
//  req_last_i   in   NUM_REQ             byte is last of packet
//  req_ready_o  out  NUM_REQ             per-requester accept
//  tx_full_i    in   1                   UART TX FIFO full
//  tx_we_o      out  1                   UART TX FIFO write enable
//  tx_din_o     out  DATA_WIDTH          UART TX FIFO write data
//  grant_o      out  $clog2(NUM_REQ)     index of current or last grant
//  busy_o       out  1                   state != IDLE
//  ovf_o        out  1                   1-cycle pulse on forced release at MAX_BEATS
// BEHAVIOUR
//  Reset values (async on rst_i):
//   - state=IDLE; grant=0; last_grant=NUM_REQ-1; beat_cnt=0.
//   - All outputs 0, including tx_din_o.
//  FSM states: IDLE, HDR (UART_ARB_HDR_EN only), XFER.
//  - IDLE:
//    - If any req_valid_i is set, register grant = first valid index searching from last_grant+1 with wrap modulo NUM_REQ.
//    - Next state is HDR if enabled, else XFER.
//    - No ready or write is issued in IDLE.
//    - Grant latency is 1 cycle from valid to ready.
//  - XFER:
//    - req_ready_o[grant] = !tx_full_i. All other ready bits are 0.
//    - Beat = req_valid_i[grant] & req_ready_o[grant].
//    - tx_we_o = beat. tx_din_o = granted byte when beat, else 0. Both are combinational, zero latency.
//    - beat_cnt increments on each beat.
//    - Beat with req_last_i[grant]: next state IDLE, last_grant <= grant, beat_cnt <= 0.
//    - Beat with beat_cnt == MAX_BEATS-1 and no last: next state IDLE, ovf_o pulses in the same cycle, last_grant <= grant.
//    - A requester that drops valid mid-packet keeps the grant; there is no timeout.
//  - Boundaries:
//    - tx_full_i=1 stalls: ready=0, no write, state held, beat_cnt held.
//    - IDLE always lasts >=1 cycle between packets, even with back-to-back requests. This is the re-arbitration bubble.
//    - A single requester re-wins after its own packet only when no other requester is valid.
//    - Reset mid-packet aborts immediately; a partial packet may remain in the UART FIFO.
//  - Width rules:
//    - beat_cnt is $clog2(MAX_BEATS+1) bits and never wraps.
//    - grant index arithmetic is modulo NUM_REQ, including non-power-of-2 values.
// CONFIGURATION
//  UART_ARB_HDR_EN defined:
//   - The HDR state follows IDLE.
//   - While !tx_full_i, writes one header byte = 8'hA0 | grant (low nibble = requester id).
//   - No req_ready_o is asserted in HDR.
//   - HDR goes to XFER after the header write. If full, HDR holds.
//   - The header does not count toward MAX_BEATS.
//  UART_ARB_HDR_EN undefined:
//   - No HDR state exists; IDLE goes directly to XFER.
//   - The output byte stream is exactly the requester payload.
// TESTING
//  1. Reset: assert rst_i async mid-cycle -> all outputs 0 immediately, busy_o=0.
//  2. Req1 alone sends 3 bytes 11,22,33(last), tx_full_i=0
//     -> grant_o=1 one cycle after valid, then 3 consecutive tx_we_o with those bytes, then IDLE.
//  3. Req0 and req2 valid together, each sending 2-byte packets; after reset last_grant=3
//     -> order req0 packet, IDLE bubble, req2 packet. Bytes never interleave.
//  4. tx_full_i high for 5 cycles mid-packet -> ready=0, no writes, byte held; resumes with the same byte on full drop.
//  5. MAX_BEATS=4, req3 streams 6 bytes without last -> 4 writes, ovf_o pulse on 4th, IDLE; re-grant sends remaining 2.
//  6. UART_ARB_HDR_EN defined, req2 sends AA(last) -> tx stream A2, AA; ready low during the A2 write.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART TX byte FIFO write port between NUM_REQ byte-stream
//   clients. A grant covers a whole packet, ending at req_last_i or when
//   MAX_BEATS bytes have been written. Clients are picked round-robin.
//   Optional build macro UART_ARB_HDR_EN: a header byte (8'hA0 | grant) is
//   written ahead of every granted packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          tx_full_i,
  output logic                          tx_we_o,
  output logic [DATA_WIDTH-1:0]         tx_din_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_o,
  output logic                          busy_o,
  output logic                          ovf_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_BEATS - 1);

`ifdef UART_ARB_HDR_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_XFER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd2} state_t;
`endif

  state_t              state;
  logic [GW-1:0]       grant_r;
  logic [GW-1:0]       last_grant;
  logic [CW-1:0]       beat_cnt;

  logic                gnt_valid;
  logic                gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic                beat;

  // First valid requester strictly after 'last', wrapping modulo NUM_REQ.
  // The sum is one bit wider so that a single conditional subtract gives a
  // correct modulo for non-power-of-2 requester counts.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic [GW:0]   idx;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = {1'b0, last} + (GW+1)'(i);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (vld[idx[GW-1:0]]) pick = idx[GW-1:0];
    end
    return pick;
  endfunction

  // Select the granted requester's valid/last/byte with constant-index slices.
  always_comb begin
    gnt_valid  = 1'b0;
    gnt_last   = 1'b0;
    gnt_data   = '0;
    gnt_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_r == GW'(k)) begin
        gnt_valid     = req_valid_i[k];
        gnt_last      = req_last_i[k];
        gnt_data      = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        gnt_onehot[k] = 1'b1;
      end
    end
  end

  // Zero-latency handshake and FIFO write path; idle outputs stay at 0.
  always_comb begin
    req_ready_o = '0;
    tx_we_o     = 1'b0;
    tx_din_o    = '0;
    ovf_o       = 1'b0;
    beat        = 1'b0;
    case (state)
      S_XFER: begin
        req_ready_o = gnt_onehot & {NUM_REQ{!tx_full_i}};
        beat        = gnt_valid & !tx_full_i;
        tx_we_o     = beat;
        if (beat) tx_din_o = gnt_data;
        ovf_o       = beat & !gnt_last & (beat_cnt == CNT_MAX);
      end
`ifdef UART_ARB_HDR_EN
      S_HDR: begin
        tx_we_o = !tx_full_i;
        if (!tx_full_i) tx_din_o = DATA_WIDTH'(8'hA0) | DATA_WIDTH'(grant_r);
      end
`endif
      default: ;
    endcase
  end

  // Arbitration FSM: IDLE picks, (HDR writes header,) XFER moves one packet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      grant_r    <= '0;
      last_grant <= LAST_INIT;
      beat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid_i) begin
            grant_r <= rr_pick(req_valid_i, last_grant);
`ifdef UART_ARB_HDR_EN
            state   <= S_HDR;
`else
            state   <= S_XFER;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        S_HDR: begin
          if (!tx_full_i) state <= S_XFER;
        end
`endif
        S_XFER: begin
          if (beat) begin
            if (gnt_last || ovf_o) begin
              state      <= S_IDLE;
              last_grant <= grant_r;
              beat_cnt   <= '0;
            end else begin
              beat_cnt   <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign grant_o = grant_r;
  assign busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed scenarios followed by a randomized phase. Each requester owns a
//   queue of bytes; a transaction-level model decides who owns the FIFO port
//   and which byte must appear, and the delivered stream per requester is
//   compared with what was offered at the end.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int GW = $clog2(N);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [N-1:0]      req_valid_i = '0;
  logic [N*DW-1:0]   req_data_i  = '0;
  logic [N-1:0]      req_last_i  = '0;
  logic [N-1:0]      req_ready_o;
  logic              tx_full_i = 1'b0;
  logic              tx_we_o;
  logic [DW-1:0]     tx_din_o;
  logic [GW-1:0]     grant_o;
  logic              busy_o;
  logic              ovf_o;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .tx_full_i(tx_full_i), .tx_we_o(tx_we_o),
    .tx_din_o(tx_din_o), .grant_o(grant_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [7:0] b; logic last; } byte_t;

  byte_t      q    [N][$];
  logic [7:0] sent [N][$];
  logic [7:0] cap  [N][$];

  int checks = 0;
  int errors = 0;
  int valid_pct  = 100;
  int full_pct   = 0;
  int full_force = 0;

  // model: 0 = nobody owns the port, 1 = header pending, 2 = packet in flight
  int m_mode  = 0;
  int m_owner = 0;
  int m_last  = N - 1;
  int m_cnt   = 0;
  int m_shown = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0 && $urandom_range(99) < 32'(valid_pct)) begin
        req_valid_i[k]            = 1'b1;
        req_data_i[k*DW +: DW]    = q[k][0].b;
        req_last_i[k]             = q[k][0].last;
      end else begin
        req_valid_i[k]            = 1'b0;
        req_data_i[k*DW +: DW]    = 8'($urandom);
        req_last_i[k]             = 1'($urandom);
      end
    end
    if (full_force >= 0) tx_full_i = (full_force != 0);
    else                 tx_full_i = ($urandom_range(99) < 32'(full_pct));
  endtask

  task automatic push_byte(input int k, input logic [7:0] b, input logic l);
    byte_t e;
    e.b = b;
    e.last = l;
    q[k].push_back(e);
    sent[k].push_back(b);
  endtask

  task automatic push_pkt(input int k, input int len, input bit with_last);
    for (int i = 0; i < len; i++) push_byte(k, 8'($urandom), with_last && (i == len - 1));
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      sent[k].delete();
      cap[k].delete();
    end
    m_mode = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_shown = 0;
  endtask

  // Compare DUT outputs with the model for the current cycle, then advance it.
  task automatic check_cycle();
    logic [N-1:0] exp_rdy = '0;
    logic         exp_we  = 1'b0;
    logic [7:0]   exp_din = 8'h00;
    logic         exp_ovf = 1'b0;
    logic         bt      = 1'b0;
    logic         lst     = 1'b0;
    if (m_mode == 2) begin
      if (!tx_full_i) exp_rdy[m_owner] = 1'b1;
      bt = req_valid_i[m_owner] && !tx_full_i;
      if (bt) begin
        exp_we  = 1'b1;
        exp_din = q[m_owner][0].b;
        lst     = q[m_owner][0].last;
        exp_ovf = !lst && (m_cnt == MB - 1);
      end
    end else if (m_mode == 1) begin
      exp_we = !tx_full_i;
      if (!tx_full_i) exp_din = 8'hA0 | 8'(m_owner);
    end
    chk("ready", 32'(req_ready_o), 32'(exp_rdy));
    chk("tx_we", 32'(tx_we_o),     32'(exp_we));
    chk("tx_din", 32'(tx_din_o),   32'(exp_din));
    chk("ovf",   32'(ovf_o),       32'(exp_ovf));
    chk("busy",  32'(busy_o),      32'(m_mode != 0));
    chk("grant", 32'(grant_o),     32'(m_shown));
    if (m_mode == 2 && tx_we_o) cap[m_owner].push_back(tx_din_o);
    case (m_mode)
      0: begin
        for (int i = 1; i <= N; i++) begin
          if (req_valid_i[(m_last + i) % N]) begin
            m_owner = (m_last + i) % N;
            m_shown = m_owner;
`ifdef UART_ARB_HDR_EN
            m_mode = 1;
`else
            m_mode = 2;
`endif
            break;
          end
        end
      end
      1: if (!tx_full_i) m_mode = 2;
      default: begin
        if (bt) begin
          void'(q[m_owner].pop_front());
          m_cnt++;
          if (lst || m_cnt == MB) begin
            m_mode = 0;
            m_last = m_owner;
            m_cnt  = 0;
          end
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk_i);
    check_cycle();
    @(posedge clk_i);
    #1;
    drive_inputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between clock edges and expect the outputs to clear at once.
  task automatic do_reset();
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_we",    32'(tx_we_o),     32'd0);
    chk("rst_din",   32'(tx_din_o),    32'd0);
    chk("rst_grant", 32'(grant_o),     32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    chk("rst_ovf",   32'(ovf_o),       32'd0);
    model_reset();
    drive_inputs();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    drive_inputs();
  endtask

  initial begin
    int bad;
    int n;
    #12;
    chk("init_ready", 32'(req_ready_o), 32'd0);
    chk("init_we",    32'(tx_we_o),     32'd0);
    chk("init_din",   32'(tx_din_o),    32'd0);
    chk("init_grant", 32'(grant_o),     32'd0);
    chk("init_busy",  32'(busy_o),      32'd0);
    chk("init_ovf",   32'(ovf_o),       32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    drive_inputs();

    // single requester, three bytes
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    drive_inputs();
    steps(8);

    // two simultaneous requesters right after reset
    do_reset();
    push_pkt(0, 2, 1'b1);
    push_pkt(2, 2, 1'b1);
    drive_inputs();
    steps(10);

    // FIFO full for five cycles in the middle of a packet
    push_pkt(3, 3, 1'b1);
    drive_inputs();
    steps(2);
    full_force = 1;
    drive_inputs();
    steps(5);
    full_force = 0;
    drive_inputs();
    steps(6);

    // forced release at MAX_BEATS, then the remainder on a fresh grant
    push_pkt(3, 6, 1'b0);
    drive_inputs();
    steps(12);
    push_byte(3, 8'h5C, 1'b1);
    drive_inputs();
    steps(4);

    // reset while a stalled packet owns the port
    push_pkt(2, 4, 1'b1);
    drive_inputs();
    steps(2);
    full_force = 1;
    drive_inputs();
    steps(2);
    do_reset();
    full_force = 0;
    drive_inputs();

    // randomized traffic with gaps in valid and random back-pressure
    valid_pct  = 80;
    full_pct   = 25;
    full_force = -1;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++)
        if (q[k].size() < 4 && $urandom_range(9) == 0) push_pkt(k, int'($urandom_range(7, 1)), 1'b1);
      drive_inputs();
      step();
    end

    valid_pct  = 100;
    full_force = 0;
    drive_inputs();
    n = 0;
    while (!(all_empty() && m_mode == 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_done", 32'(all_empty() && m_mode == 0), 32'd1);

    for (int k = 0; k < N; k++) begin
      chk($sformatf("stream_len_r%0d", k), 32'(cap[k].size()), 32'(sent[k].size()));
      bad = 0;
      for (int i = 0; i < sent[k].size() && i < cap[k].size(); i++)
        if (cap[k][i] !== sent[k][i]) bad++;
      chk($sformatf("stream_data_r%0d", k), 32'(bad), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
